// File: rtl/memristor_infra_multiplier_axi4_ctrl.sv
// AXI4-Lite slave around a signed sequential shift-add multiplier.
// Products are buffered in a small FIFO and drained through RESULT reads.
module memristor_infra_multiplier_axi4_ctrl #(
    parameter int OP_W       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] AWADDR,
    input  logic [2:0]  AWPROT,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic [2:0]  ARPROT,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        IRQ
);
    localparam int PW   = 2 * OP_W;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int STPW = $clog2(OP_W) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_PUSH = 2'd2;

    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_STAT = 8'h04;
    localparam logic [7:0] A_MPLR = 8'h08;
    localparam logic [7:0] A_MCND = 8'h0C;
    localparam logic [7:0] A_RES  = 8'h10;

    logic            awready_q, wready_q, bvalid_q;
    logic [1:0]      bresp_q;
    logic [7:0]      awaddr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic            rvalid_q;
    logic [1:0]      rresp_q;
    logic [31:0]     rdata_q;

    logic [1:0]      state;
    logic [STPW-1:0] step;
    logic            start_q;
    logic [OP_W:0]   mplier;
    logic [PW-1:0]   mcand, acc;
    logic            neg;

    logic [OP_W-1:0] op_a, op_b;
    logic            irq_en, done, ovf, irq_q;

    logic [PW-1:0]   mem [FIFO_DEPTH];
    logic [PTRW-1:0] wptr, rptr;
    logic [CNTW-1:0] count;

    logic            wr_fire, wr_err, wr_ok;
    logic [31:0]     wmask;
    logic            sel_ctrl, sel_stat, sel_mplr, sel_mcnd;
    logic            ctrl_wr, do_start, do_clr, w1c_done, w1c_ovf;
    logic            busy, start_blk;
    logic [PW-1:0]   product;
    logic            push_evt, push_ok, full, empty;
    logic            ar_fire, rd_err, pop;
    logic [31:0]     rd_data, stat_word;
    logic            done_n, ovf_n, ien_n;
    logic            unused_bits;

    function automatic logic [OP_W:0] mag(input logic [OP_W-1:0] v);
        logic [OP_W:0] e;
        e = {v[OP_W-1], v};
        return e[OP_W] ? -e : e;
    endfunction

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = ~rvalid_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;
    assign IRQ     = irq_q;

    assign unused_bits = ^{AWADDR[31:8], ARADDR[31:8], AWPROT, ARPROT};

    assign wr_fire  = ~awready_q & ~wready_q & ~bvalid_q;
    assign wmask    = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}},
                       {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    assign sel_ctrl = awaddr_q == A_CTRL;
    assign sel_stat = awaddr_q == A_STAT;
    assign sel_mplr = awaddr_q == A_MPLR;
    assign sel_mcnd = awaddr_q == A_MCND;

    assign busy      = state != S_IDLE;
    // The finishing PUSH cycle may already accept the next START.
    assign start_blk = start_q | (state == S_CALC);

    always_comb begin
        wr_err = 1'b0;
        unique case (1'b1)
            sel_ctrl: wr_err = wstrb_q[0] & wdata_q[0] & start_blk;
            sel_stat: wr_err = |(wdata_q & wmask & ~32'h12);
            sel_mplr: wr_err = 1'b0;
            sel_mcnd: wr_err = 1'b0;
            default:  wr_err = 1'b1;
        endcase
    end

    assign wr_ok    = wr_fire & ~wr_err;
    assign ctrl_wr  = wr_ok & sel_ctrl & wstrb_q[0];
    assign do_clr   = ctrl_wr & wdata_q[1];
    assign do_start = ctrl_wr & wdata_q[0] & ~wdata_q[1];
    assign w1c_done = wr_ok & sel_stat & wstrb_q[0] & wdata_q[1];
    assign w1c_ovf  = wr_ok & sel_stat & wstrb_q[0] & wdata_q[4];

    assign product  = neg ? -acc : acc;
    assign full     = count == CNTW'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign push_evt = (state == S_PUSH) & ~do_clr;
    assign push_ok  = push_evt & ~full;

    always_comb begin
        stat_word            = '0;
        stat_word[0]         = busy;
        stat_word[1]         = done;
        stat_word[2]         = empty;
        stat_word[3]         = full;
        stat_word[4]         = ovf;
        stat_word[8 +: CNTW] = count;
    end

    assign ar_fire = ARVALID & ~rvalid_q;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (ARADDR[7:0])
            A_CTRL: rd_data = {29'd0, irq_en, 2'd0};
            A_STAT: rd_data = stat_word;
            A_MPLR: rd_data = 32'(op_a);
            A_MCND: rd_data = 32'(op_b);
            A_RES: begin
                if (empty) rd_err = 1'b1;
                else       rd_data = 32'($signed(mem[rptr]));
            end
            default: rd_err = 1'b1;
        endcase
    end

    assign pop = ar_fire & (ARADDR[7:0] == A_RES) & ~empty;

    always_comb begin
        done_n = do_clr ? 1'b0 : ((done & ~w1c_done) | push_evt);
        ovf_n  = do_clr ? 1'b0 : ((ovf & ~w1c_ovf) | (push_evt & full));
        ien_n  = ctrl_wr ? wdata_q[2] : irq_en;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            if (AWVALID && awready_q) begin
                awready_q <= 1'b0;
                awaddr_q  <= AWADDR[7:0];
            end
            if (WVALID && wready_q) begin
                wready_q <= 1'b0;
                wdata_q  <= WDATA;
                wstrb_q  <= WSTRB;
            end
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? 2'b10 : 2'b00;
            end else if (bvalid_q && BREADY) begin
                bvalid_q  <= 1'b0;
                awready_q <= 1'b1;
                wready_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? 2'b10 : 2'b00;
        end else if (rvalid_q && RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            op_a <= '0;
            op_b <= '0;
        end else begin
            if (wr_ok && sel_mplr)
                op_a <= (wdata_q[OP_W-1:0] & wmask[OP_W-1:0])
                      | (op_a & ~wmask[OP_W-1:0]);
            if (wr_ok && sel_mcnd)
                op_b <= (wdata_q[OP_W-1:0] & wmask[OP_W-1:0])
                      | (op_b & ~wmask[OP_W-1:0]);
        end
    end

    // Operands are latched on the START write; the FSM leaves IDLE one edge later.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= S_IDLE;
            step    <= '0;
            start_q <= 1'b0;
            mplier  <= '0;
            mcand   <= '0;
            acc     <= '0;
            neg     <= 1'b0;
        end else if (do_clr) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
        end else begin
            start_q <= do_start;
            if (do_start) begin
                mplier <= mag(op_a);
                mcand  <= PW'(mag(op_b));
                neg    <= op_a[OP_W-1] ^ op_b[OP_W-1];
                acc    <= '0;
            end
            unique case (state)
                S_IDLE: begin
                    if (start_q) begin
                        state <= S_CALC;
                        step  <= '0;
                    end
                end
                S_CALC: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= step + STPW'(1);
                    if (step == STPW'(OP_W - 1)) state <= S_PUSH;
                end
                S_PUSH:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_ok) mem[wptr] <= product;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET || do_clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTRW'(1);
            if (pop)     rptr <= rptr + PTRW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            done   <= 1'b0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            done   <= done_n;
            ovf    <= ovf_n;
            irq_en <= ien_n;
            irq_q  <= ien_n & (done_n | ovf_n);
        end
    end

endmodule

// File: tb/tb_memristor_infra_multiplier_axi4_ctrl.sv
// Scoreboard bench for memristor_infra_multiplier_axi4_ctrl.
// Products are queued at START and checked when RESULT is read.
module tb_memristor_infra_multiplier_axi4_ctrl;
    localparam int OP_W  = 4;
    localparam int DEPTH = 4;
    localparam logic [41:0] RST_VEC =
        {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0};

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY, ARVALID, ARREADY;
    logic        RVALID, RREADY, IRQ;
    logic [41:0] out_vec;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 ACLK = ~ACLK;

    assign out_vec = {AWREADY, WREADY, ARREADY, BVALID, BRESP,
                      RVALID, RRESP, RDATA, IRQ};

    memristor_infra_multiplier_axi4_ctrl #(
        .OP_W(OP_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB),
        .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP),
        .RVALID(RVALID), .RREADY(RREADY),
        .IRQ(IRQ)
    );

    function automatic logic [31:0] model(input logic [OP_W-1:0] a,
                                          input logic [OP_W-1:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 32'(sa * sb);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write_req(input logic [7:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
        bit aw_ok = 0;
        bit w_ok = 0;
        bit aw_r, w_r;
        int n = 0;
        AWADDR = {24'h0, a};
        WDATA = d;
        WSTRB = s;
        AWVALID = 1'b1;
        WVALID = 1'b1;
        while (!(aw_ok && w_ok) && n < 20) begin
            aw_r = AWREADY & AWVALID;
            w_r = WREADY & WVALID;
            @(posedge ACLK);
            #1;
            n++;
            if (aw_r) begin aw_ok = 1; AWVALID = 1'b0; end
            if (w_r) begin w_ok = 1; WVALID = 1'b0; end
        end
        n = 0;
        while (!BVALID && n < 20) begin
            tick(1);
            n++;
        end
        if (!BVALID) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_timeout addr=%h: BVALID got 0 want 1", a);
            AWVALID = 1'b0;
            WVALID = 1'b0;
        end
    endtask

    task automatic axi_write_resp(output logic [1:0] r);
        r = BRESP;
        BREADY = 1'b1;
        tick(1);
        BREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r);
        axi_write_req(a, d, s);
        axi_write_resp(r);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                            output logic [1:0] r);
        bit ok = 0;
        bit ar_r;
        int n = 0;
        ARADDR = {24'h0, a};
        ARVALID = 1'b1;
        while (!ok && n < 20) begin
            ar_r = ARREADY;
            tick(1);
            n++;
            if (ar_r) begin ok = 1; ARVALID = 1'b0; end
        end
        n = 0;
        while (!RVALID && n < 20) begin
            tick(1);
            n++;
        end
        if (!ok || !RVALID) begin
            n_cmp++;
            n_bad++;
            $display("FAIL read_timeout addr=%h: RVALID got %b want 1", a, RVALID);
            ARVALID = 1'b0;
        end
        d = RDATA;
        r = RRESP;
        RREADY = 1'b1;
        tick(1);
        RREADY = 1'b0;
    endtask

    task automatic run_mul(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                           input logic [31:0] ctrl, output logic [1:0] r);
        logic [1:0] t;
        axi_write(8'h08, 32'(a), 4'hF, t);
        axi_write(8'h0C, 32'(b), 4'hF, t);
        axi_write(8'h00, ctrl, 4'hF, r);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0] r;
        ARESET = 1'b1;
        tick(3);
        n_cmp++;
        if (out_vec !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want %h", out_vec, RST_VEC);
        end
        ARESET = 1'b0;
        tick(1);
        axi_read(8'h04, d, r);
        n_cmp++;
        if (d !== 32'h4 || r !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_status: got %h/%b want 00000004/00", d, r);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d, e;
        logic [1:0] r;
        run_mul(4'h3, 4'hB, 32'h1, r);
        exp_q.push_back(model(4'h3, 4'hB));
        tick(8);
        axi_read(8'h04, d, r);
        n_cmp++;
        if (d !== 32'h102 || r !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_status: got %h/%b want 00000102/00", d, r);
        end
        e = exp_q.pop_front();
        axi_read(8'h10, d, r);
        n_cmp++;
        if (d !== e || r !== 2'b00 || e !== 32'hFFFFFFF1) begin
            n_bad++;
            $display("FAIL basic_result: got %h/%b want %h/00", d, r, e);
        end
        axi_read(8'h04, d, r);
        n_cmp++;
        if (d !== 32'h6) begin
            n_bad++;
            $display("FAIL basic_empty: got %h want 00000006", d);
        end
    endtask

    task automatic test_edge_values();
        logic [31:0] d, e;
        logic [1:0] r;
        axi_write(8'h08, 32'hFFFFFFFF, 4'hF, r);
        axi_read(8'h08, d, r);
        n_cmp++;
        if (d !== 32'hF) begin
            n_bad++;
            $display("FAIL operand_mask: got %h want 0000000f", d);
        end
        axi_write(8'h08, 32'h0, 4'b1110, r);
        axi_read(8'h08, d, r);
        n_cmp++;
        if (d !== 32'hF) begin
            n_bad++;
            $display("FAIL operand_strobe: got %h want 0000000f", d);
        end
        for (int i = 0; i < 2; i++) begin
            logic [OP_W-1:0] a;
            a = (i == 0) ? 4'h8 : 4'h7;
            run_mul(a, 4'h8, 32'h1, r);
            exp_q.push_back(model(a, 4'h8));
            tick(8);
            e = exp_q.pop_front();
            axi_read(8'h10, d, r);
            n_cmp++;
            if (d !== e || r !== 2'b00) begin
                n_bad++;
                $display("FAIL edge_result%0d: got %h/%b want %h/00", i, d, r, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, e;
        logic [1:0] r;
        axi_write(8'h00, 32'h2, 4'hF, r);
        for (int k = 1; k <= 5; k++) begin
            run_mul(4'h1, 4'(k), 32'h1, r);
            if (exp_q.size() < DEPTH) exp_q.push_back(model(4'h1, 4'(k)));
            n_cmp++;
            if (r !== 2'b00) begin
                n_bad++;
                $display("FAIL b2b_start%0d: got %b want 00", k, r);
            end
            tick(5);
        end
        tick(4);
        axi_read(8'h04, d, r);
        n_cmp++;
        if (d !== 32'h41A) begin
            n_bad++;
            $display("FAIL b2b_status: got %h want 0000041a", d);
        end
        for (int k = 0; k < 5; k++) begin
            axi_read(8'h10, d, r);
            n_cmp++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (d !== e || r !== 2'b00) begin
                    n_bad++;
                    $display("FAIL b2b_read%0d: got %h/%b want %h/00", k, d, r, e);
                end
            end else if (d !== 32'h0 || r !== 2'b10) begin
                n_bad++;
                $display("FAIL b2b_empty_read: got %h/%b want 00000000/10", d, r);
            end
        end
        axi_write(8'h04, 32'h12, 4'hF, r);
        axi_read(8'h04, d, r);
        n_cmp++;
        if (d !== 32'h4) begin
            n_bad++;
            $display("FAIL b2b_w1c: got %h want 00000004", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d, e;
        logic [1:0] r;
        axi_write(8'h20, 32'h1, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10) begin
            n_bad++;
            $display("FAIL unmapped_write: got %b want 10", r);
        end
        axi_read(8'h24, d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_bad++;
            $display("FAIL unmapped_read: got %h/%b want 00000000/10", d, r);
        end
        axi_write(8'h10, 32'h5, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10) begin
            n_bad++;
            $display("FAIL result_write: got %b want 10", r);
        end
        axi_write(8'h04, 32'h1, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10) begin
            n_bad++;
            $display("FAIL status_ro_write: got %b want 10", r);
        end
        run_mul(4'h3, 4'h2, 32'h1, r);
        exp_q.push_back(model(4'h3, 4'h2));
        axi_write(8'h00, 32'h1, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10) begin
            n_bad++;
            $display("FAIL start_busy: got %b want 10", r);
        end
        tick(8);
        axi_read(8'h04, d, r);
        n_cmp++;
        if (d !== 32'h102) begin
            n_bad++;
            $display("FAIL start_busy_count: got %h want 00000102", d);
        end
        e = exp_q.pop_front();
        axi_read(8'h10, d, r);
        n_cmp++;
        if (d !== e || r !== 2'b00) begin
            n_bad++;
            $display("FAIL start_busy_result: got %h/%b want %h/00", d, r, e);
        end
        axi_read(8'h10, d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_bad++;
            $display("FAIL start_busy_extra: got %h/%b want 00000000/10", d, r);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d, e;
        logic [1:0] r;
        axi_write(8'h00, 32'h6, 4'hF, r);
        run_mul(4'h2, 4'h3, 32'h5, r);
        exp_q.push_back(model(4'h2, 4'h3));
        tick(4);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_early: got %b want 0", IRQ);
        end
        tick(1);
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_rise: got %b want 1", IRQ);
        end
        axi_write_req(8'h04, 32'h2, 4'hF);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_w1c_drop: got %b want 0", IRQ);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
                n_bad++;
                $display("FAIL bresp_hold%0d: got %b/%b want 1/00", i, BVALID, BRESP);
            end
            tick(1);
        end
        axi_write_resp(r);
        e = exp_q.pop_front();
        axi_read(8'h10, d, r);
        n_cmp++;
        if (d !== e || r !== 2'b00) begin
            n_bad++;
            $display("FAIL irq_result: got %h/%b want %h/00", d, r, e);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] d, e;
        logic [1:0] r;
        run_mul(4'h5, 4'h5, 32'h5, r);
        exp_q.push_back(model(4'h5, 4'h5));
        tick(8);
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_irq: got %b want 1", IRQ);
        end
        axi_write(8'h00, 32'h5, 4'hF, r);
        tick(2);
        ARESET = 1'b1;
        tick(1);
        n_cmp++;
        if (out_vec !== RST_VEC) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h want %h", out_vec, RST_VEC);
        end
        ARESET = 1'b0;
        exp_q.delete();
        tick(1);
        axi_read(8'h04, d, r);
        n_cmp++;
        if (d !== 32'h4) begin
            n_bad++;
            $display("FAIL mid_reset_status: got %h want 00000004", d);
        end
        run_mul(4'h2, 4'h3, 32'h1, r);
        exp_q.push_back(model(4'h2, 4'h3));
        tick(8);
        e = exp_q.pop_front();
        axi_read(8'h10, d, r);
        n_cmp++;
        if (d !== e || r !== 2'b00) begin
            n_bad++;
            $display("FAIL post_reset_result: got %h/%b want %h/00", d, r, e);
        end
    endtask

    initial begin
        ARESET = 1'b1;
        AWADDR = '0;
        AWPROT = '0;
        AWVALID = 1'b0;
        WDATA = '0;
        WSTRB = '0;
        WVALID = 1'b0;
        BREADY = 1'b0;
        ARADDR = '0;
        ARPROT = '0;
        ARVALID = 1'b0;
        RREADY = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_edge_values();
        test_back_to_back();
        test_errors();
        test_irq();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
